// File: rtl/core_mem_rd_agu.sv
// core_mem_rd_agu: read-address generator for the core memory MAC read port.
// Streams a row_len x num_rows tile of GBUS words from WMEM (mem_sel=0) or
// the KV cache (mem_sel=1) towards the LBUF, pausing while the LBUF reports
// almost-full. The first word is issued in the same cycle the start is
// accepted, so cmem_ren rises the cycle after start.
// Optional: define CORE_MEM_RD_AGU_STALL_CNT_EN to add the stall_cnt output.
module core_mem_rd_agu #(
    parameter int GBUS_ADDR = 16,
    parameter int CNT_W     = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mem_sel,
    input  logic [GBUS_ADDR-2:0] base_addr,
    input  logic [CNT_W-1:0]     row_len,
    input  logic [CNT_W-1:0]     num_rows,
    input  logic [CNT_W-1:0]     stride,
    input  logic                 lbuf_almost_full,
    output logic [GBUS_ADDR-1:0] cmem_raddr,
    output logic                 cmem_ren,
    output logic                 busy,
    output logic                 done
`ifdef CORE_MEM_RD_AGU_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int AW = GBUS_ADDR - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_mem_sel, w_mem_sel_nxt;
    logic [AW-1:0]          r_row_base, w_row_base_nxt;
    logic [CNT_W-1:0]       r_col, w_col_nxt;
    logic [CNT_W-1:0]       r_row, w_row_nxt;
    logic [CNT_W-1:0]       r_row_len, w_row_len_nxt;
    logic [CNT_W-1:0]       r_num_rows, w_num_rows_nxt;
    logic [CNT_W-1:0]       r_stride, w_stride_nxt;
    logic [GBUS_ADDR-1:0]   r_raddr, w_raddr_nxt;
    logic                   r_ren, w_ren_nxt;
    logic                   r_done, w_done_nxt;

    // Working view of the tile: live inputs on the accept cycle, latched
    // config afterwards, so the accept cycle can issue the first word itself.
    logic                   w_cur_sel;
    logic [AW-1:0]          w_cur_base;
    logic [CNT_W-1:0]       w_cur_col;
    logic [CNT_W-1:0]       w_cur_row;
    logic [CNT_W-1:0]       w_cur_len;
    logic [CNT_W-1:0]       w_cur_rows;
    logic [CNT_W-1:0]       w_cur_stride;
    logic                   w_issue;
    logic                   w_start_acc;

    assign w_start_acc = (r_state == S_IDLE) && start && !abort;

    // Next-state, counter and registered-output computation.
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_sel_nxt  = r_mem_sel;
        w_row_base_nxt = r_row_base;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_row_len_nxt  = r_row_len;
        w_num_rows_nxt = r_num_rows;
        w_stride_nxt   = r_stride;
        w_raddr_nxt    = r_raddr;
        w_ren_nxt      = 1'b0;
        w_done_nxt     = 1'b0;
        w_issue        = 1'b0;
        w_cur_sel      = r_mem_sel;
        w_cur_base     = r_row_base;
        w_cur_col      = r_col;
        w_cur_row      = r_row;
        w_cur_len      = r_row_len;
        w_cur_rows     = r_num_rows;
        w_cur_stride   = r_stride;

        unique case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_cur_sel      = mem_sel;
                    w_cur_base     = base_addr;
                    w_cur_col      = '0;
                    w_cur_row      = '0;
                    w_cur_len      = row_len;
                    w_cur_rows     = num_rows;
                    w_cur_stride   = stride;
                    w_mem_sel_nxt  = mem_sel;
                    w_row_base_nxt = base_addr;
                    w_col_nxt      = '0;
                    w_row_nxt      = '0;
                    w_row_len_nxt  = row_len;
                    w_num_rows_nxt = num_rows;
                    w_stride_nxt   = stride;
                    if (row_len == '0 || num_rows == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_issue     = !lbuf_almost_full;
                    end
                end
            end
            S_ISSUE: begin
                w_issue = !lbuf_almost_full;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_ren_nxt   = 1'b1;
            w_raddr_nxt = {w_cur_sel, w_cur_base + AW'(w_cur_col)};
            if (w_cur_col == w_cur_len - CNT_W'(1)) begin
                w_col_nxt      = '0;
                w_row_base_nxt = w_cur_base + AW'(w_cur_stride);
                w_row_nxt      = w_cur_row + CNT_W'(1);
                if (w_cur_row == w_cur_rows - CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end else begin
                w_col_nxt = w_cur_col + CNT_W'(1);
            end
        end

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_ren_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    // State, counters, latched config and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_mem_sel  <= 1'b0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_len  <= '0;
            r_num_rows <= '0;
            r_stride   <= '0;
            r_raddr    <= '0;
            r_ren      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_sel  <= w_mem_sel_nxt;
            r_row_base <= w_row_base_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_row_len  <= w_row_len_nxt;
            r_num_rows <= w_num_rows_nxt;
            r_stride   <= w_stride_nxt;
            r_raddr    <= w_raddr_nxt;
            r_ren      <= w_ren_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign cmem_raddr = r_raddr;
    assign cmem_ren   = r_ren;
    assign busy       = (r_state == S_ISSUE);
    assign done       = r_done;

`ifdef CORE_MEM_RD_AGU_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count ISSUE cycles blocked by almost-full, saturating; cleared on start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_ISSUE && lbuf_almost_full && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_core_mem_rd_agu.sv
// Scoreboard bench for core_mem_rd_agu: stimulus pushes expected read
// addresses and done pulses (with their cycle numbers) into queues; a
// negedge monitor pops and compares whenever cmem_ren or done is high.
module tb_core_mem_rd_agu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic        mem_sel;
    logic [14:0] base_addr;
    logic [11:0] row_len;
    logic [11:0] num_rows;
    logic [11:0] stride;
    logic        lbuf_almost_full;
    logic [15:0] cmem_raddr;
    logic        cmem_ren;
    logic        busy;
    logic        done;
`ifdef CORE_MEM_RD_AGU_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    core_mem_rd_agu #(.GBUS_ADDR(16), .CNT_W(12)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .abort            (abort),
        .mem_sel          (mem_sel),
        .base_addr        (base_addr),
        .row_len          (row_len),
        .num_rows         (num_rows),
        .stride           (stride),
        .lbuf_almost_full (lbuf_almost_full),
        .cmem_raddr       (cmem_raddr),
        .cmem_ren         (cmem_ren),
        .busy             (busy),
        .done             (done)
`ifdef CORE_MEM_RD_AGU_STALL_CNT_EN
        ,
        .stall_cnt        (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        int unsigned cyc;
    } exp_t;

    exp_t        ren_q[$];
    int unsigned done_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic void check_eq(string name, longint unsigned act, longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic step(int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ren(logic [15:0] addr, int unsigned c);
        exp_t e;
        e.addr = addr;
        e.cyc  = c;
        ren_q.push_back(e);
    endtask

    // Drive a one-cycle start; t is the cycle in which start is presented.
    task automatic start_tile(logic sel, logic [14:0] base, logic [11:0] len,
                              logic [11:0] rows, logic [11:0] str, output int unsigned t);
        mem_sel   = sel;
        base_addr = base;
        row_len   = len;
        num_rows  = rows;
        stride    = str;
        start     = 1'b1;
        t         = cyc;
        step();
        start     = 1'b0;
        base_addr = 15'h5A5A;
        row_len   = 12'd7;
        num_rows  = 12'd7;
        stride    = 12'd3;
        mem_sel   = ~sel;
    endtask

    // Monitor: every strobe and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (cmem_ren) begin
            if (ren_q.size() == 0) begin
                check_eq("unexpected_ren", {16'h0, cmem_raddr}, 32'hDEAD0000);
            end else begin
                exp_t e;
                e = ren_q.pop_front();
                check_eq("ren_addr", cmem_raddr, e.addr);
                check_eq("ren_cycle", cyc, e.cyc);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check_eq("unexpected_done", cyc, 0);
            end else begin
                int unsigned dc;
                dc = done_q.pop_front();
                check_eq("done_cycle", cyc, dc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        logic [15:0] basic[8];
        basic = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                  16'h0110, 16'h0111, 16'h0112, 16'h0113};

        rstn = 1'b0; start = 1'b0; abort = 1'b0; mem_sel = 1'b0;
        base_addr = '0; row_len = '0; num_rows = '0; stride = '0;
        lbuf_almost_full = 1'b0;
        step(3);
        check_eq("rst_ren", cmem_ren, 0);
        check_eq("rst_raddr", cmem_raddr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
`ifdef CORE_MEM_RD_AGU_STALL_CNT_EN
        check_eq("rst_stall_cnt", stall_cnt, 0);
`endif
        rstn = 1'b1;
        step(2);

        // Basic 4x2 tile in WMEM
        for (int i = 0; i < 8; i++) push_ren(basic[i], cyc + 1 + i);
        done_q.push_back(cyc + 9);
        start_tile(1'b0, 15'h0100, 12'd4, 12'd2, 12'h010, t);
        check_eq("basic_busy_first", busy, 1);
        step(7);
        check_eq("basic_busy_last_issue", busy, 0);
        step(1);
        check_eq("basic_busy_after_done", busy, 0);
        step(2);

        // KV region with in-region wrap
        push_ren(16'hFFFE, cyc + 1);
        push_ren(16'hFFFF, cyc + 2);
        push_ren(16'h8000, cyc + 3);
        push_ren(16'h8001, cyc + 4);
        done_q.push_back(cyc + 5);
        start_tile(1'b1, 15'h7FFE, 12'd4, 12'd1, 12'h005, t);
        step(6);

        // Backpressure: almost_full high for three cycles after the 2nd issue
        push_ren(16'h0100, cyc + 1);
        push_ren(16'h0101, cyc + 2);
        for (int i = 2; i < 8; i++) push_ren(basic[i], cyc + 4 + i);
        done_q.push_back(cyc + 12);
        start_tile(1'b0, 15'h0100, 12'd4, 12'd2, 12'h010, t);
        step(1);
        lbuf_almost_full = 1'b1;
        step(2);
        check_eq("bp_busy_stalled", busy, 1);
        step(1);
        lbuf_almost_full = 1'b0;
        step(8);
`ifdef CORE_MEM_RD_AGU_STALL_CNT_EN
        check_eq("bp_stall_cnt", stall_cnt, 3);
`endif
        step(2);

        // Degenerate tiles: no reads, second start in DONE ignored
        done_q.push_back(cyc + 2);
        start_tile(1'b0, 15'h0040, 12'd0, 12'd2, 12'h010, t);
        check_eq("degen_busy_done", busy, 0);
        mem_sel = 1'b0; base_addr = 15'h0300; row_len = 12'd4; num_rows = 12'd2;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_eq("degen_restart_ignored", busy, 0);
        step(3);
        done_q.push_back(cyc + 2);
        start_tile(1'b1, 15'h0040, 12'd3, 12'd0, 12'h010, t);
        step(4);

        // Abort after the 5th issue, then an immediate new start
        for (int i = 0; i < 5; i++) push_ren(basic[i], cyc + 1 + i);
        start_tile(1'b0, 15'h0100, 12'd4, 12'd2, 12'h010, t);
        step(4);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        push_ren(16'h8200, cyc + 1);
        push_ren(16'h8201, cyc + 2);
        push_ren(16'h8220, cyc + 3);
        push_ren(16'h8221, cyc + 4);
        done_q.push_back(cyc + 5);
        start_tile(1'b1, 15'h0200, 12'd2, 12'd2, 12'h020, t);
        step(6);

        // Reset mid-tile, then the full tile again
        push_ren(16'h0100, cyc + 1);
        push_ren(16'h0101, cyc + 2);
        start_tile(1'b0, 15'h0100, 12'd4, 12'd2, 12'h010, t);
        step(1);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        check_eq("midrst_ren", cmem_ren, 0);
        check_eq("midrst_raddr", cmem_raddr, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        for (int i = 0; i < 8; i++) push_ren(basic[i], cyc + 1 + i);
        done_q.push_back(cyc + 9);
        start_tile(1'b0, 15'h0100, 12'd4, 12'd2, 12'h010, t);
        step(12);

        check_eq("ren_queue_drained", ren_q.size(), 0);
        check_eq("done_queue_drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_mem_rd_agu.md
Name: core_mem_rd_agu

Overview:
- Read-address generator that drives the core memory's MAC read channel (cmem_raddr/cmem_ren).
- Streams a 2-D tile of GBUS words out of WMEM or KV cache into the LBUF.
- Throttles on lbuf_almost_full so the LBUF never overflows; in-flight reads are absorbed by the LBUF alert margin.
- Sits directly upstream of the core memory, between the core controller and the CMEM read port.

Parameters:
- GBUS_ADDR, 16: CMEM address width; MSB selects region (0 = WMEM, 1 = KV cache).
- CNT_W, 12: width of the row_len, num_rows and stride fields and of the internal counters.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches config and begins a tile (accepted only in IDLE)
- abort  in  1  synchronous cancel; returns to IDLE, no done
- mem_sel  in  1  region select, driven onto cmem_raddr[GBUS_ADDR-1]
- base_addr  in  GBUS_ADDR-1  tile start address within the region
- row_len  in  CNT_W  GBUS words per row
- num_rows  in  CNT_W  rows per tile
- stride  in  CNT_W  address increment between row starts
- lbuf_almost_full  in  1  backpressure from the core memory
- cmem_raddr  out  GBUS_ADDR  read address (registered)
- cmem_ren  out  1  read strobe (registered)
- busy  out  1  high from the cycle after start accept through the last issue
- done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset (rstn low at posedge): state IDLE, all counters 0, cmem_ren=0, cmem_raddr=0, busy=0, done=0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - On start, latch mem_sel, base_addr, row_len, num_rows, stride.
  - row_base=base_addr, col=0, row=0.
  - If row_len==0 or num_rows==0, go to DONE with no reads; otherwise go to ISSUE.
- ISSUE:
  - Each cycle, if lbuf_almost_full==0 (sampled this cycle), the next cycle presents cmem_ren=1 with cmem_raddr={mem_sel, row_base+col}. Otherwise the next cycle has cmem_ren=0 (stall) and counters hold.
  - After an issue: if col==row_len-1, then col=0, row_base+=stride, row+=1; else col+=1.
  - Issuing the last word (row==num_rows-1, col==row_len-1) moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE and IDLE.
- Latency:
  - start at cycle T → first cmem_ren at T+1, provided almost_full is low at T.
  - done pulses the cycle after the last cmem_ren.
  - Total cycles for an unstalled tile = row_len*num_rows+1 from start to done.
- cmem_ren is never high on two consecutive cycles in which almost_full was high on the prior cycle. Stalls insert no extra gaps once almost_full drops.
- Arithmetic:
  - row_base+col and row_base+stride are computed modulo 2^(GBUS_ADDR-1), wrapping silently within the region.
  - The MSB is always the latched mem_sel and is never carried into.
- start while busy or in DONE: ignored. The config inputs are don't-care outside the start cycle.
- abort: wins over every other event, including a coincident start or last issue. Next cycle: IDLE, cmem_ren=0, no done pulse. Reads already issued are not recalled.
- Reset mid-tile: identical to abort, plus all registers return to reset values.
- Config is latched, so input changes during a tile have no effect.

Optional Feature:
- Macro: CORE_MEM_RD_AGU_STALL_CNT_EN.
- Enabled:
  - Adds output stall_cnt [31:0], cleared on accepted start.
  - Increments each ISSUE cycle in which almost_full blocks an issue, saturating at 2^32-1.
  - Holds its value after done until the next start; reset value 0.
- Disabled: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic tile: mem_sel=0, base=0x0100, row_len=4, num_rows=2, stride=0x10, almost_full=0.
  - Response: cmem_ren on 8 consecutive cycles, addresses 0x0100–0x0103 then 0x0110–0x0113.
  - done exactly 9 cycles after start.
- KV region and wrap: mem_sel=1, base=0x7FFE, row_len=4, num_rows=1.
  - Response: addresses 0xFFFE, 0xFFFF, 0x8000, 0x8001; MSB stays 1.
- Backpressure: same tile as the basic case, almost_full held high for 3 cycles after the 2nd issue.
  - Response: exactly a 3-cycle gap in cmem_ren, address sequence unchanged, done 12 cycles after start.
  - With the macro enabled, stall_cnt=3.
- Degenerate: row_len=0 → done one cycle after IDLE→DONE, no cmem_ren.
  - A second start during that DONE cycle is ignored.
- Abort: abort asserted after the 5th issue of a 4x2 tile.
  - Response: no further cmem_ren, no done, busy=0 the next cycle.
  - A new start is accepted immediately.
- Reset mid-tile: rstn low for 1 cycle during ISSUE.
  - Response: all outputs 0 the next cycle, state IDLE.
  - A restarted tile produces the full address sequence from base.
